// File: rtl/ysyx_24110006_lsu.sv
`default_nettype none
// ysyx_24110006_lsu: load/store unit, one word-aligned bus transaction per instruction.
// Rev 1.0 - initial release
module ysyx_24110006_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [3:0]  i_mem_wmask,
  input  logic [2:0]  i_mem_read_t,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_result,
  input  logic        i_reg_wen,
  output logic        o_req_valid,
  output logic        o_req_wen,
  output logic [31:0] o_req_addr,
  output logic [31:0] o_req_wdata,
  output logic [3:0]  o_req_wstrb,
  input  logic        i_req_ready,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_rdata,
  input  logic        i_rsp_err,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic        o_reg_wen,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_read_t;
  logic        r_is_load;
  logic [31:0] r_result;
  logic        r_reg_wen;
  logic [31:0] r_cnt;

  logic        w_half;
  logic        w_word;
  logic        w_misaligned;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  assign o_ready = (r_state == IDLE);

  // Access size comes from wmask for stores (store wins over ren), from funct3 for loads
  always_comb begin
    w_half = 1'b0;
    w_word = 1'b0;
    if (i_mem_wen) begin
      w_half = (i_mem_wmask == 4'b0011);
      w_word = (i_mem_wmask == 4'b1111);
    end else begin
      case (i_mem_read_t)
        3'b000, 3'b100: ;
        3'b001, 3'b101: w_half = 1'b1;
        default:        w_word = 1'b1;
      endcase
    end
    w_misaligned = (w_half & i_mem_addr[0]) | (w_word & (i_mem_addr[1:0] != 2'b00));
  end

  always_comb begin
    w_shifted = i_rsp_rdata >> {r_off, 3'b000};
    case (r_read_t)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_off         <= 2'd0;
      r_read_t      <= 3'd0;
      r_is_load     <= 1'b0;
      r_result      <= 32'd0;
      r_reg_wen     <= 1'b0;
      r_cnt         <= 32'd0;
      o_req_valid   <= 1'b0;
      o_req_wen     <= 1'b0;
      o_req_addr    <= 32'd0;
      o_req_wdata   <= 32'd0;
      o_req_wstrb   <= 4'd0;
      o_valid       <= 1'b0;
      o_wb_data     <= 32'd0;
      o_reg_wen     <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_cause <= 2'b00;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_off     <= i_mem_addr[1:0];
            r_read_t  <= i_mem_read_t;
            r_is_load <= i_mem_ren & ~i_mem_wen;
            r_result  <= i_result;
            r_reg_wen <= i_reg_wen;
            if (!(i_mem_ren || i_mem_wen)) begin
              r_state       <= DONE;
              o_valid       <= 1'b1;
              o_wb_data     <= i_result;
              o_reg_wen     <= i_reg_wen;
              o_fault       <= 1'b0;
              o_fault_cause <= 2'b00;
            end else if (w_misaligned) begin
              r_state       <= DONE;
              o_valid       <= 1'b1;
              o_wb_data     <= i_result;
              o_reg_wen     <= 1'b0;
              o_fault       <= 1'b1;
              o_fault_cause <= 2'b01;
            end else begin
              r_state     <= REQ;
              o_req_valid <= 1'b1;
              o_req_wen   <= i_mem_wen;
              o_req_addr  <= {i_mem_addr[31:2], 2'b00};
              o_req_wdata <= i_wdata << {i_mem_addr[1:0], 3'b000};
              o_req_wstrb <= i_mem_wen ? 4'(i_mem_wmask << i_mem_addr[1:0]) : 4'b0000;
            end
          end
        end
        REQ: begin
          if (i_req_ready) begin
            o_req_valid <= 1'b0;
            r_cnt       <= 32'd0;
            r_state     <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_valid) begin
            r_state       <= DONE;
            o_valid       <= 1'b1;
            o_wb_data     <= r_is_load ? w_load_data : r_result;
            o_reg_wen     <= r_reg_wen & ~i_rsp_err;
            o_fault       <= i_rsp_err;
            o_fault_cause <= i_rsp_err ? 2'b10 : 2'b00;
          end else begin
            r_cnt <= r_cnt + 32'd1;
            if ((TIMEOUT != 0) && (r_cnt + 32'd1 == 32'(TIMEOUT))) begin
              r_state       <= DONE;
              o_valid       <= 1'b1;
              o_wb_data     <= r_result;
              o_reg_wen     <= 1'b0;
              o_fault       <= 1'b1;
              o_fault_cause <= 2'b11;
            end
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110006_lsu.sv
`default_nettype none
// Testbench for ysyx_24110006_lsu: vector table driven through a bus responder, scoreboard on o_valid.
module tb_ysyx_24110006_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, o_ready;
  logic        i_mem_ren = 1'b0, i_mem_wen = 1'b0;
  logic [3:0]  i_mem_wmask = 4'd0;
  logic [2:0]  i_mem_read_t = 3'd0;
  logic [31:0] i_mem_addr = 32'd0, i_wdata = 32'd0, i_result = 32'd0;
  logic        i_reg_wen = 1'b0;
  logic        o_req_valid, o_req_wen;
  logic [31:0] o_req_addr, o_req_wdata;
  logic [3:0]  o_req_wstrb;
  logic        i_req_ready = 1'b0, i_rsp_valid = 1'b0, i_rsp_err = 1'b0;
  logic [31:0] i_rsp_rdata = 32'd0;
  logic        o_valid, o_reg_wen, o_fault;
  logic [31:0] o_wb_data;
  logic [1:0]  o_fault_cause;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24110006_lsu #(.TIMEOUT(4)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask),
    .i_mem_read_t(i_mem_read_t), .i_mem_addr(i_mem_addr), .i_wdata(i_wdata),
    .i_result(i_result), .i_reg_wen(i_reg_wen),
    .o_req_valid(o_req_valid), .o_req_wen(o_req_wen), .o_req_addr(o_req_addr),
    .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
    .o_valid(o_valid), .o_wb_data(o_wb_data), .o_reg_wen(o_reg_wen),
    .o_fault(o_fault), .o_fault_cause(o_fault_cause)
  );

  typedef struct {
    string       name;
    logic        ren, wen;
    logic [3:0]  wmask;
    logic [2:0]  read_t;
    logic [31:0] addr, wdata, result;
    logic        reg_wen;
    int          req_wait;
    logic [31:0] rdata;
    logic        err, no_rsp;
    logic        exp_req;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wb;
    logic        chk_wb, exp_reg_wen;
    logic [1:0]  exp_cause;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] wb;
    logic        chk_wb, reg_wen;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every write-back pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_o_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_wb) chk({e.name, "_wb"}, o_wb_data, e.wb);
        chk({e.name, "_reg_wen"}, 32'(o_reg_wen), 32'(e.reg_wen));
        chk({e.name, "_fault"}, 32'(o_fault), 32'(e.cause != 2'b00));
        chk({e.name, "_cause"}, 32'(o_fault_cause), 32'(e.cause));
      end
    end
  end

  function automatic vec_t base(string n);
    vec_t t;
    t.name = n; t.ren = 0; t.wen = 0; t.wmask = 0; t.read_t = 0;
    t.addr = 0; t.wdata = 0; t.result = 32'hCAFE_0000; t.reg_wen = 0;
    t.req_wait = 0; t.rdata = 0; t.err = 0; t.no_rsp = 0;
    t.exp_req = 0; t.exp_addr = 0; t.exp_wdata = 0; t.exp_wstrb = 0;
    t.exp_wb = 0; t.chk_wb = 0; t.exp_reg_wen = 0; t.exp_cause = 0;
    return t;
  endfunction

  function automatic vec_t ld(string n, logic [2:0] rt, logic [31:0] a, logic [31:0] rd, logic [31:0] wb);
    vec_t t;
    t = base(n);
    t.ren = 1; t.read_t = rt; t.addr = a; t.rdata = rd; t.reg_wen = 1;
    t.exp_req = 1; t.exp_addr = {a[31:2], 2'b00}; t.exp_wb = wb; t.chk_wb = 1; t.exp_reg_wen = 1;
    return t;
  endfunction

  function automatic vec_t st(string n, logic [3:0] m, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] strb, logic [31:0] ewd);
    vec_t t;
    t = base(n);
    t.wen = 1; t.wmask = m; t.addr = a; t.wdata = wd; t.result = 32'h5A5A_0000 ^ a;
    t.exp_req = 1; t.exp_addr = {a[31:2], 2'b00}; t.exp_wstrb = strb; t.exp_wdata = ewd;
    t.exp_wb = t.result; t.chk_wb = 1;
    return t;
  endfunction

  function automatic vec_t misal(vec_t t);
    vec_t r;
    r = t;
    r.name = {t.name, "_misal"}; r.reg_wen = 1;
    r.exp_req = 0; r.chk_wb = 0; r.exp_reg_wen = 0; r.exp_cause = 2'b01;
    return r;
  endfunction

  task automatic run_vec(vec_t v);
    exp_t e;
    int   k;
    @(negedge clk);
    chk({v.name, "_ready"}, 32'(o_ready), 32'd1);
    i_valid = 1; i_mem_ren = v.ren; i_mem_wen = v.wen; i_mem_wmask = v.wmask;
    i_mem_read_t = v.read_t; i_mem_addr = v.addr; i_wdata = v.wdata;
    i_result = v.result; i_reg_wen = v.reg_wen;
    e.name = v.name; e.wb = v.exp_wb; e.chk_wb = v.chk_wb;
    e.reg_wen = v.exp_reg_wen; e.cause = v.exp_cause;
    sb.push_back(e);
    @(negedge clk);
    i_valid = 0;
    if (!v.exp_req) begin
      chk({v.name, "_no_req"}, 32'(o_req_valid), 32'd0);
      chk({v.name, "_lat1"}, 32'(o_valid), 32'd1);
    end else begin
      chk({v.name, "_req_valid"}, 32'(o_req_valid), 32'd1);
      // Stall the bus; stray responses, new i_valid and changed inputs must not disturb the request
      for (int w = 0; w < v.req_wait; w++) begin
        i_valid = 1; i_mem_addr = 32'h0000_0000; i_wdata = 32'hFFFF_FFFF;
        i_rsp_valid = 1; i_rsp_rdata = 32'h1111_1111;
        @(negedge clk);
        chk({v.name, "_req_hold"}, 32'(o_req_valid), 32'd1);
        chk({v.name, "_addr_hold"}, o_req_addr, v.exp_addr);
      end
      i_valid = 0;
      chk({v.name, "_req_addr"}, o_req_addr, v.exp_addr);
      chk({v.name, "_req_wen"}, 32'(o_req_wen), 32'(v.wen));
      chk({v.name, "_req_wstrb"}, 32'(o_req_wstrb), 32'(v.exp_wstrb));
      if (v.wen) chk({v.name, "_req_wdata"}, o_req_wdata, v.exp_wdata);
      i_req_ready = 1;
      @(negedge clk);
      i_req_ready = 0; i_rsp_valid = 0;
      chk({v.name, "_req_drop"}, 32'(o_req_valid), 32'd0);
      chk({v.name, "_no_early_valid"}, 32'(o_valid), 32'd0);
      if (v.no_rsp) begin
        k = 0;
        while (k < 20 && !o_valid) begin
          @(negedge clk);
          k++;
        end
        chk({v.name, "_timeout_lat"}, 32'(k), 32'd4);
      end else begin
        i_rsp_valid = 1; i_rsp_rdata = v.rdata; i_rsp_err = v.err;
        @(negedge clk);
        i_rsp_valid = 0; i_rsp_err = 0;
        chk({v.name, "_rsp_lat"}, 32'(o_valid), 32'd1);
      end
    end
    @(negedge clk);
    chk({v.name, "_pulse"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    vec_t t;
    t = base("alu"); t.result = 32'h0000_1234; t.reg_wen = 1;
    t.exp_wb = 32'h0000_1234; t.chk_wb = 1; t.exp_reg_wen = 1;
    vecs.push_back(t);
    vecs.push_back(ld("lb", 3'b000, 32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80));
    vecs.push_back(ld("lbu", 3'b100, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080));
    t = st("sh", 4'b0011, 32'h8000_0002, 32'hABCD_1234, 4'b1100, 32'h1234_0000);
    t.req_wait = 3;
    vecs.push_back(t);
    vecs.push_back(misal(ld("lw", 3'b010, 32'h8000_0001, 32'd0, 32'd0)));
    t = ld("lh_err", 3'b001, 32'h8000_0002, 32'h1234_5678, 32'd0);
    t.err = 1; t.chk_wb = 0; t.exp_reg_wen = 0; t.exp_cause = 2'b10;
    vecs.push_back(t);
    t = ld("lw", 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    t.req_wait = 1;
    vecs.push_back(t);
    vecs.push_back(ld("lhu", 3'b101, 32'h8000_0002, 32'h8001_7FFF, 32'h0000_8001));
    vecs.push_back(ld("lh", 3'b001, 32'h8000_0000, 32'h7FFF_8001, 32'hFFFF_8001));
    vecs.push_back(st("sb", 4'b0001, 32'h8000_0001, 32'h0000_00A5, 4'b0010, 32'h0000_A500));
    t = st("sw_ren", 4'b1111, 32'h8000_0010, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
    t.ren = 1; t.read_t = 3'b000;
    vecs.push_back(t);
    t = ld("timeout", 3'b010, 32'h8000_0008, 32'd0, 32'd0);
    t.no_rsp = 1; t.chk_wb = 0; t.exp_reg_wen = 0; t.exp_cause = 2'b11;
    vecs.push_back(t);
    vecs.push_back(misal(ld("rt7", 3'b111, 32'h8000_0002, 32'd0, 32'd0)));
    vecs.push_back(misal(st("sh1", 4'b0011, 32'h8000_0001, 32'd0, 4'd0, 32'd0)));

    repeat (3) @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_req_valid", 32'(o_req_valid), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_reg_wen", 32'(o_reg_wen), 32'd0);
    chk("rst_wb", o_wb_data, 32'd0);
    chk("rst_cause", 32'(o_fault_cause), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for a response, then a stale response must be dropped
    @(negedge clk);
    i_valid = 1; i_mem_ren = 1; i_mem_wen = 0; i_mem_read_t = 3'b010;
    i_mem_addr = 32'h8000_0020; i_reg_wen = 1;
    @(negedge clk);
    i_valid = 0;
    chk("rstmid_req", 32'(o_req_valid), 32'd1);
    i_req_ready = 1;
    @(negedge clk);
    i_req_ready = 0;
    chk("rstmid_in_rsp", 32'(o_req_valid), 32'd0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rstmid_ready", 32'(o_ready), 32'd1);
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    i_rsp_valid = 1; i_rsp_rdata = 32'h7777_7777;
    @(negedge clk);
    i_rsp_valid = 0;
    chk("stale_rsp", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("stale_rsp2", 32'(o_valid), 32'd0);
    run_vec(ld("after_rst", 3'b010, 32'h8000_0024, 32'h0123_4567, 32'h0123_4567));

    repeat (2) @(negedge clk);
    if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
